htable_tx_sequencer: RTL

- Sequences the dump of the 256x32 histogram table RAM to the UART transmit FIFO once the histogram engine has finished.
- Reads one 32-bit entry per word slot, splits it into 4 bytes MSB-first, and pushes each byte with a write-enable pulse.
- Stalls on FIFO full and reports done only after the FIFO has drained.
- Replaces the ad-hoc transmit sub-FSM in the FPGA top level.

---
 rtl/htable_tx_sequencer_if.sv | 32 +++
 rtl/htable_tx_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/htable_tx_sequencer_if.sv
// Port bundle of the histogram table dump sequencer: control strobes,
// RAM read port and UART tx FIFO push port.
interface htable_tx_sequencer_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic          start_i;
    logic          abort_i;
    logic          ram_en_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_data_i;
    logic          tx_active_o;
    logic          tx_wr_en_o;
    logic [7:0]    tx_wdata_o;
    logic          tx_full_i;
    logic          tx_empty_i;
    logic          busy_o;
    logic          done_o;
    logic [AW+2:0] byte_cnt_o;

    modport slave (
        input  start_i, abort_i, ram_data_i, tx_full_i, tx_empty_i,
        output ram_en_o, ram_addr_o, tx_active_o, tx_wr_en_o,
        output tx_wdata_o, busy_o, done_o, byte_cnt_o
    );

    modport master (
        output start_i, abort_i, ram_data_i, tx_full_i, tx_empty_i,
        input  ram_en_o, ram_addr_o, tx_active_o, tx_wr_en_o,
        input  tx_wdata_o, busy_o, done_o, byte_cnt_o
    );
endinterface

// File: rtl/htable_tx_sequencer.sv
// Dumps the histogram table RAM to the UART tx FIFO, MSB byte first.
// HTABLE_TX_CHECKSUM_EN appends an 8-bit mod-256 sum of all data bytes.
module htable_tx_sequencer #(
    parameter int DEPTH = 256,
    parameter int AW    = 9,
    parameter int DW    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    htable_tx_sequencer_if.slave bus
);
    localparam int NB = DW / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = AW + 3;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NB - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_LOAD,
        S_PUSH,
        S_DRAIN,
        S_DONE
`ifdef HTABLE_TX_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [CW-1:0] r_byte_cnt;
    logic [DW-1:0] r_shreg;
    logic [IW-1:0] r_idx;
    logic          r_ram_en;
    logic          r_tx_active;
    logic          r_wr_en;
    logic [7:0]    r_wdata;
    logic          r_busy;
    logic          r_done;
`ifdef HTABLE_TX_CHECKSUM_EN
    logic [7:0]    r_sum;
`endif

    logic [7:0]    w_byte;
    logic          w_last_byte;
    logic          w_last_word;
    logic [CW-1:0] w_cnt_inc;

    assign w_byte      = r_shreg[DW-1 -: 8];
    assign w_last_byte = (r_idx == LAST_IDX);
    assign w_last_word = (r_addr == LAST_ADDR);
    assign w_cnt_inc   = r_byte_cnt + CW'(1);

    // Dump FSM; every output is a register so strobes are glitch-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_byte_cnt  <= '0;
            r_shreg     <= '0;
            r_idx       <= '0;
            r_ram_en    <= 1'b0;
            r_tx_active <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef HTABLE_TX_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else if (bus.abort_i) begin
            r_state     <= S_IDLE;
            r_ram_en    <= 1'b0;
            r_tx_active <= 1'b0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_ram_en <= 1'b0;
            r_wr_en  <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start_i) begin
                        r_addr      <= '0;
                        r_byte_cnt  <= '0;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_tx_active <= 1'b1;
                        r_ram_en    <= 1'b1;
                        r_state     <= S_RD_REQ;
`ifdef HTABLE_TX_CHECKSUM_EN
                        r_sum       <= '0;
`endif
                    end
                end
                S_RD_REQ: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shreg <= bus.ram_data_i;
                    r_idx   <= '0;
                    r_state <= S_PUSH;
                end
                S_PUSH: begin
                    if (!bus.tx_full_i) begin
                        r_wr_en    <= 1'b1;
                        r_wdata    <= w_byte;
                        r_shreg    <= r_shreg << 8;
                        r_idx      <= r_idx + IW'(1);
                        r_byte_cnt <= w_cnt_inc;
`ifdef HTABLE_TX_CHECKSUM_EN
                        r_sum      <= r_sum + w_byte;
`endif
                        if (w_last_byte) begin
                            if (w_last_word) begin
`ifdef HTABLE_TX_CHECKSUM_EN
                                r_state <= S_CSUM;
`else
                                r_state <= S_DRAIN;
`endif
                            end else begin
                                r_addr   <= r_addr + AW'(1);
                                r_ram_en <= 1'b1;
                                r_state  <= S_RD_REQ;
                            end
                        end
                    end
                end
`ifdef HTABLE_TX_CHECKSUM_EN
                S_CSUM: begin
                    if (!bus.tx_full_i) begin
                        r_wr_en    <= 1'b1;
                        r_wdata    <= r_sum;
                        r_byte_cnt <= w_cnt_inc;
                        r_state    <= S_DRAIN;
                    end
                end
`endif
                S_DRAIN: begin
                    if (bus.tx_empty_i) begin
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_tx_active <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ram_en_o    = r_ram_en;
    assign bus.ram_addr_o  = r_addr;
    assign bus.tx_active_o = r_tx_active;
    assign bus.tx_wr_en_o  = r_wr_en;
    assign bus.tx_wdata_o  = r_wdata;
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.byte_cnt_o  = r_byte_cnt;
endmodule
